qmem_width_bridge: RTL and testbench

Single-clock QMEM downsizing bridge: one MDW-bit master access becomes RATIO = MDW/SDW sequential SDW-bit slave accesses, most-significant lane first. Successor to the fixed 32-to-16 async bridge, with these additions:
- generalised ratio
- back-to-back slave beats
- error termination
- optional skipping of byte-disabled beats

Sits between a wide CPU/ctrl QMEM master and a narrow QMEM slave (SRAM/SDRAM ctrl port) in the same clock domain.

---
 rtl/qmem_width_bridge.sv | 162 ++++++++++++++++
 tb/tb_qmem_width_bridge.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qmem_width_bridge.sv
// QMEM downsizing bridge: one MDW-bit access becomes MDW/SDW SDW-bit beats, MS lane first (QMEM_BRIDGE_SKIP_EN skips sel-less beats).
// Latency: m_ack in cycle beats+1 after acceptance with a zero-wait slave; each slave wait state adds one cycle.
// Backpressure: master holds m_cs until m_ack; each beat holds s_cs until s_ack or s_err.
module qmem_width_bridge #(
  parameter int MAW = 22,
  parameter int MDW = 32,
  parameter int SDW = 16,
  localparam int MSW = MDW/8,
  localparam int SSW = SDW/8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [MAW-1:0] m_adr,
  input  logic           m_cs,
  input  logic           m_we,
  input  logic [MSW-1:0] m_sel,
  input  logic [MDW-1:0] m_dat_w,
  output logic [MDW-1:0] m_dat_r,
  output logic           m_ack,
  output logic           m_err,
  output logic [MAW-1:0] s_adr,
  output logic           s_cs,
  output logic           s_we,
  output logic [SSW-1:0] s_sel,
  output logic [SDW-1:0] s_dat_w,
  input  logic [SDW-1:0] s_dat_r,
  input  logic           s_ack,
  input  logic           s_err
);

  localparam int RATIO = MDW/SDW;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int SSB   = $clog2(SSW);
  localparam int MSB   = $clog2(MSW);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [MAW-1:0] adr_q;
  logic           we_q;
  logic [MSW-1:0] sel_q;
  logic [MDW-1:0] dat_q;

  logic           first_ok, next_ok;
  logic [CW-1:0]  first_k, next_k;

  // Beat k serves lane RATIO-1-k, so the most significant lane goes out first.
  function automatic int lane_of(input logic [CW-1:0] k);
    return RATIO - 1 - int'(k);
  endfunction

  function automatic logic [MAW-1:0] beat_adr(input logic [MAW-1:0] adr, input logic [CW-1:0] k);
    logic [MAW-1:0] base;
    base = adr & ~((MAW'(1) << MSB) - MAW'(1));
    return base | (MAW'(k) << SSB);
  endfunction

  function automatic logic [SSW-1:0] lane_sel(input logic [MSW-1:0] sel, input logic [CW-1:0] k);
    return sel[lane_of(k)*SSW +: SSW];
  endfunction

  function automatic logic [SDW-1:0] lane_dat(input logic [MDW-1:0] dat, input logic [CW-1:0] k);
    return dat[lane_of(k)*SDW +: SDW];
  endfunction

  always_comb begin
    first_ok = 1'b1;
    first_k  = '0;
    next_ok  = 1'b0;
    next_k   = '0;
`ifdef QMEM_BRIDGE_SKIP_EN
    // Downward scan leaves the lowest qualifying beat index in place.
    first_ok = 1'b0;
    for (int k = RATIO-1; k >= 0; k--) begin
      if (lane_sel(m_sel, CW'(k)) != '0) begin
        first_ok = 1'b1;
        first_k  = CW'(k);
      end
      if (k > int'(cnt) && lane_sel(sel_q, CW'(k)) != '0) begin
        next_ok = 1'b1;
        next_k  = CW'(k);
      end
    end
`else
    next_ok = (int'(cnt) != RATIO-1);
    next_k  = cnt + CW'(1);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      m_dat_r <= '0;
      m_ack   <= 1'b0;
      m_err   <= 1'b0;
      s_adr   <= '0;
      s_cs    <= 1'b0;
      s_we    <= 1'b0;
      s_sel   <= '0;
      s_dat_w <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m_cs && !m_ack) begin
            adr_q   <= m_adr;
            we_q    <= m_we;
            sel_q   <= m_sel;
            dat_q   <= m_dat_w;
            m_dat_r <= '0;
            if (first_ok) begin
              cnt     <= first_k;
              s_cs    <= 1'b1;
              s_we    <= m_we;
              s_adr   <= beat_adr(m_adr, first_k);
              s_sel   <= lane_sel(m_sel, first_k);
              s_dat_w <= lane_dat(m_dat_w, first_k);
              state   <= BUSY;
            end else begin
              m_ack <= 1'b1;
              state <= ACK;
            end
          end
        end
        BUSY: begin
          if (s_cs && (s_ack || s_err)) begin
            if (!we_q)
              m_dat_r[lane_of(cnt)*SDW +: SDW] <= s_dat_r;
            if (s_err) begin
              s_cs  <= 1'b0;
              m_ack <= 1'b1;
              m_err <= 1'b1;
              state <= ACK;
            end else if (!next_ok) begin
              s_cs  <= 1'b0;
              m_ack <= 1'b1;
              state <= ACK;
            end else begin
              // Next beat loads on the completing edge: no idle cycle on the slave bus.
              cnt     <= next_k;
              s_adr   <= beat_adr(adr_q, next_k);
              s_sel   <= lane_sel(sel_q, next_k);
              s_dat_w <= lane_dat(dat_q, next_k);
            end
          end
        end
        ACK: begin
          m_ack <= 1'b0;
          m_err <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qmem_width_bridge.sv
// Scoreboard bench for qmem_width_bridge: three instances (32/16, 64/16, 32/8) with a scripted slave model.
module tb_qmem_width_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Master-side stimulus (index 0: 32/16, 1: 64/16, 2: 32/8)
  logic [21:0] madr [3];
  logic [2:0]  mcs, mwe;
  logic [7:0]  msel [3];
  logic [63:0] mdw  [3];

  // Slave model outputs
  logic [2:0]  sack, serr;
  logic [15:0] sdr [3];

  // Per-instance DUT outputs
  wire [31:0] a_mdr, c_mdr;
  wire [63:0] b_mdr;
  wire        a_ack, b_ack, c_ack, a_err, b_err, c_err;
  wire        a_scs, b_scs, c_scs, a_swe, b_swe, c_swe;
  wire [21:0] a_sadr, b_sadr, c_sadr;
  wire [1:0]  a_ssel, b_ssel;
  wire [0:0]  c_ssel;
  wire [15:0] a_sdw, b_sdw;
  wire [7:0]  c_sdw;

  wire [63:0] mdr  [3];
  wire [21:0] sadr [3];
  wire [1:0]  ssel [3];
  wire [15:0] sdw  [3];
  wire [2:0]  mack = {c_ack, b_ack, a_ack};
  wire [2:0]  merr = {c_err, b_err, a_err};
  wire [2:0]  scs  = {c_scs, b_scs, a_scs};
  wire [2:0]  swe  = {c_swe, b_swe, a_swe};

  assign mdr[0]  = {32'h0, a_mdr};
  assign mdr[1]  = b_mdr;
  assign mdr[2]  = {32'h0, c_mdr};
  assign sadr[0] = a_sadr;
  assign sadr[1] = b_sadr;
  assign sadr[2] = c_sadr;
  assign ssel[0] = a_ssel;
  assign ssel[1] = b_ssel;
  assign ssel[2] = {1'b0, c_ssel};
  assign sdw[0]  = a_sdw;
  assign sdw[1]  = b_sdw;
  assign sdw[2]  = {8'h0, c_sdw};

  qmem_width_bridge #(.MAW(22), .MDW(32), .SDW(16)) u_a (
    .clk(clk), .rst_n(rst_n), .m_adr(madr[0]), .m_cs(mcs[0]), .m_we(mwe[0]),
    .m_sel(msel[0][3:0]), .m_dat_w(mdw[0][31:0]), .m_dat_r(a_mdr), .m_ack(a_ack), .m_err(a_err),
    .s_adr(a_sadr), .s_cs(a_scs), .s_we(a_swe), .s_sel(a_ssel), .s_dat_w(a_sdw),
    .s_dat_r(sdr[0]), .s_ack(sack[0]), .s_err(serr[0]));

  qmem_width_bridge #(.MAW(22), .MDW(64), .SDW(16)) u_b (
    .clk(clk), .rst_n(rst_n), .m_adr(madr[1]), .m_cs(mcs[1]), .m_we(mwe[1]),
    .m_sel(msel[1]), .m_dat_w(mdw[1]), .m_dat_r(b_mdr), .m_ack(b_ack), .m_err(b_err),
    .s_adr(b_sadr), .s_cs(b_scs), .s_we(b_swe), .s_sel(b_ssel), .s_dat_w(b_sdw),
    .s_dat_r(sdr[1]), .s_ack(sack[1]), .s_err(serr[1]));

  qmem_width_bridge #(.MAW(22), .MDW(32), .SDW(8)) u_c (
    .clk(clk), .rst_n(rst_n), .m_adr(madr[2]), .m_cs(mcs[2]), .m_we(mwe[2]),
    .m_sel(msel[2][3:0]), .m_dat_w(mdw[2][31:0]), .m_dat_r(c_mdr), .m_ack(c_ack), .m_err(c_err),
    .s_adr(c_sadr), .s_cs(c_scs), .s_we(c_swe), .s_sel(c_ssel), .s_dat_w(c_sdw),
    .s_dat_r(sdr[2][7:0]), .s_ack(sack[2]), .s_err(serr[2]));

  // Slave model: ws wait states per beat, s_err on beat errb, data from rd[] in issue order
  int          ws [3];
  int          errb [3];
  int          wcnt [3];
  int          bcnt [3];
  logic [15:0] rd [3][8];

  always_comb begin
    sack = '0;
    serr = '0;
    for (int i = 0; i < 3; i++) begin
      sack[i] = scs[i] && (wcnt[i] == ws[i]) && (bcnt[i] != errb[i]);
      serr[i] = scs[i] && (wcnt[i] == ws[i]) && (bcnt[i] == errb[i]);
      sdr[i]  = rd[i][bcnt[i] % 8];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        wcnt[i] <= 0;
        bcnt[i] <= 0;
      end else begin
        if (scs[i]) begin
          if (wcnt[i] == ws[i]) begin
            wcnt[i] <= 0;
            bcnt[i] <= bcnt[i] + 1;
          end else begin
            wcnt[i] <= wcnt[i] + 1;
          end
        end
        if (mack[i]) bcnt[i] <= 0;
      end
    end
  end

  // Scoreboard
  typedef struct packed {
    logic [21:0] adr;
    logic [1:0]  sel;
    logic        we;
    logic [15:0] dat;
  } beat_t;

  typedef struct {
    logic [63:0] dat;
    logic        err;
    int          cyc;
  } ack_t;

  beat_t bq [3][$];
  ack_t  aq [3][$];
  beat_t got_b, exp_b;
  ack_t  exp_a;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input int i, input logic [21:0] adr, input logic [1:0] sel,
                           input logic we, input logic [15:0] dat);
    beat_t b;
    b.adr = adr; b.sel = sel; b.we = we; b.dat = dat;
    bq[i].push_back(b);
  endtask

  task automatic push_ack(input int i, input logic [63:0] dat, input logic err, input int at_cyc);
    ack_t a;
    a.dat = dat; a.err = err; a.cyc = at_cyc;
    aq[i].push_back(a);
  endtask

  // Drives a request after a falling edge; the next rising edge (cyc+1) is the acceptance edge.
  task automatic start_txn(input int i, input logic [21:0] adr, input logic we, input logic [7:0] sel,
                           input logic [63:0] dw, input logic [63:0] exp_dat, input logic exp_err,
                           input int lat, input bit expect_ack);
    @(negedge clk);
    madr[i] = adr; mwe[i] = we; msel[i] = sel; mdw[i] = dw; mcs[i] = 1'b1;
    if (expect_ack) push_ack(i, exp_dat, exp_err, cyc + 1 + lat);
  endtask

  task automatic wait_ack(input int i, input string name);
    bit got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (mack[i]) got = 1'b1;
    end
    mcs[i] = 1'b0;
    chk({name, "_ack_seen"}, 64'(got), 64'd1);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (scs[i] && (sack[i] || serr[i])) begin
        n_chk++;
        got_b = {sadr[i], ssel[i], swe[i], sdw[i]};
        if (bq[i].size() == 0) begin
          n_fail++;
          $display("FAIL beat%0d: got beat %h, expected none", i, got_b);
        end else begin
          exp_b = bq[i].pop_front();
          if (got_b !== exp_b) begin
            n_fail++;
            $display("FAIL beat%0d: got adr/sel/we/dat %h, expected %h", i, got_b, exp_b);
          end
        end
      end
      if (mack[i]) begin
        if (aq[i].size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL ack%0d: got m_ack at cycle %0d, expected none", i, cyc);
        end else begin
          exp_a = aq[i].pop_front();
          chk($sformatf("ack%0d_dat", i), mdr[i], exp_a.dat);
          chk($sformatf("ack%0d_err", i), 64'(merr[i]), 64'(exp_a.err));
          chk($sformatf("ack%0d_cycle", i), 64'(cyc), 64'(exp_a.cyc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    mcs = '0;
    mwe = '0;
    for (int i = 0; i < 3; i++) begin
      madr[i] = '0; msel[i] = '0; mdw[i] = '0;
      ws[i] = 0; errb[i] = -1;
      for (int k = 0; k < 8; k++) rd[i][k] = '0;
    end
    rd[0][0] = 16'hAAAA; rd[0][1] = 16'h5555;
    rd[1][0] = 16'h0BAD; rd[1][1] = 16'hF00D;
    rd[2][0] = 16'h003C; rd[2][1] = 16'h0000; rd[2][2] = 16'h0077; rd[2][3] = 16'h00E1;
    ws[1] = 2;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_slave%0d", i), {20'h0, sadr[i], ssel[i], swe[i], sdw[i], scs[i]}, 64'h0);
      chk($sformatf("rst_master%0d", i), {mdr[i][61:0], mack[i], merr[i]} | mdr[i], 64'h0);
    end
    rst_n = 1'b1;

    // 32/16 read, zero-wait slave
    push_beat(0, 22'h104, 2'b11, 1'b0, 16'h0);
    push_beat(0, 22'h106, 2'b11, 1'b0, 16'h0);
    start_txn(0, 22'h104, 1'b0, 8'h0F, 64'h0, 64'hAAAA5555, 1'b0, 2, 1'b1);
    wait_ack(0, "rd32");

    // 64/16 write, two wait states per beat
    push_beat(1, 22'h200, 2'b11, 1'b1, 16'h1122);
    push_beat(1, 22'h202, 2'b11, 1'b1, 16'h3344);
`ifdef QMEM_BRIDGE_SKIP_EN
    start_txn(1, 22'h200, 1'b1, 8'hF0, 64'h1122334455667788, 64'h0, 1'b0, 6, 1'b1);
`else
    push_beat(1, 22'h204, 2'b00, 1'b1, 16'h5566);
    push_beat(1, 22'h206, 2'b00, 1'b1, 16'h7788);
    start_txn(1, 22'h200, 1'b1, 8'hF0, 64'h1122334455667788, 64'h0, 1'b0, 12, 1'b1);
`endif
    wait_ack(1, "wr64");

    // 32/8 read with error on beat 1
    errb[2] = 1;
    push_beat(2, 22'h300, 2'b01, 1'b0, 16'h0);
    push_beat(2, 22'h301, 2'b01, 1'b0, 16'h0);
    start_txn(2, 22'h300, 1'b0, 8'h0F, 64'h0, 64'h3C000000, 1'b1, 2, 1'b1);
    wait_ack(2, "err8");
    errb[2] = -1;
    @(negedge clk);
    chk("err8_after", {61'h0, scs[2], mack[2], merr[2]}, 64'h0);

    // 32/8 read with sparse byte enables
    rd[2][1] = 16'h005A;
    push_beat(2, 22'h010, 2'b01, 1'b0, 16'h0);
`ifdef QMEM_BRIDGE_SKIP_EN
    push_beat(2, 22'h012, 2'b01, 1'b0, 16'h0);
    start_txn(2, 22'h011, 1'b0, 8'h0A, 64'h0, 64'h3C005A00, 1'b0, 2, 1'b1);
`else
    push_beat(2, 22'h011, 2'b00, 1'b0, 16'h0);
    push_beat(2, 22'h012, 2'b01, 1'b0, 16'h0);
    push_beat(2, 22'h013, 2'b00, 1'b0, 16'h0);
    start_txn(2, 22'h011, 1'b0, 8'h0A, 64'h0, 64'h3C5A77E1, 1'b0, 4, 1'b1);
`endif
    wait_ack(2, "sparse8");

    // 32/16 write, upper lane disabled
`ifdef QMEM_BRIDGE_SKIP_EN
    push_beat(0, 22'h602, 2'b11, 1'b1, 16'hBEEF);
    start_txn(0, 22'h600, 1'b1, 8'h03, 64'hDEADBEEF, 64'h0, 1'b0, 1, 1'b1);
`else
    push_beat(0, 22'h600, 2'b00, 1'b1, 16'hDEAD);
    push_beat(0, 22'h602, 2'b11, 1'b1, 16'hBEEF);
    start_txn(0, 22'h600, 1'b1, 8'h03, 64'hDEADBEEF, 64'h0, 1'b0, 2, 1'b1);
`endif
    wait_ack(0, "wr32");

    // 32/16 read with all byte enables off
`ifdef QMEM_BRIDGE_SKIP_EN
    start_txn(0, 22'h500, 1'b0, 8'h00, 64'h0, 64'h0, 1'b0, 0, 1'b1);
`else
    push_beat(0, 22'h500, 2'b00, 1'b0, 16'h0);
    push_beat(0, 22'h502, 2'b00, 1'b0, 16'h0);
    start_txn(0, 22'h500, 1'b0, 8'h00, 64'h0, 64'hAAAA5555, 1'b0, 2, 1'b1);
`endif
    wait_ack(0, "sel0");

    // Back-to-back reads with m_cs held high
    push_beat(0, 22'h200, 2'b11, 1'b0, 16'h0);
    push_beat(0, 22'h202, 2'b11, 1'b0, 16'h0);
    start_txn(0, 22'h200, 1'b0, 8'h0F, 64'h0, 64'hAAAA5555, 1'b0, 2, 1'b1);
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (mack[0]) got = 1'b1;
    end
    chk("b2b_first_ack_seen", 64'(got), 64'd1);
    madr[0] = 22'h208;
    push_beat(0, 22'h208, 2'b11, 1'b0, 16'h0);
    push_beat(0, 22'h20A, 2'b11, 1'b0, 16'h0);
    push_ack(0, 64'hAAAA5555, 1'b0, cyc + 4);
    chk("b2b_scs_in_ack", 64'(scs[0]), 64'd0);
    @(negedge clk);
    chk("b2b_gap", {62'h0, scs[0], mack[0]}, 64'h0);
    wait_ack(0, "b2b2");

    // Reset while beat 1 of 2 is pending
    ws[0] = 2;
    push_beat(0, 22'h400, 2'b11, 1'b0, 16'h0);
    start_txn(0, 22'h400, 1'b0, 8'h0F, 64'h0, 64'h0, 1'b0, 0, 1'b0);
    repeat (4) @(negedge clk);
    chk("mid_scs", 64'(scs[0]), 64'd1);
    chk("mid_dat", mdr[0], 64'hAAAA0000);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out", {mdr[0][60:0], scs[0], mack[0], merr[0]} | mdr[0], 64'h0);
    mcs[0] = 1'b0;
    ws[0] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    push_beat(0, 22'h104, 2'b11, 1'b0, 16'h0);
    push_beat(0, 22'h106, 2'b11, 1'b0, 16'h0);
    start_txn(0, 22'h104, 1'b0, 8'h0F, 64'h0, 64'hAAAA5555, 1'b0, 2, 1'b1);
    wait_ack(0, "post_rst");

    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("beats_left%0d", i), 64'(bq[i].size()), 64'd0);
      chk($sformatf("acks_left%0d", i), 64'(aq[i].size()), 64'd0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
